// File: rtl/n_encoder_seq_if.sv
`default_nettype none
// ============================================================================
// Module      : n_encoder_seq_if
// Description : Load/request and valid/ready index stream bundle for the
//               sequential n-bit encoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface n_encoder_seq_if #(
    parameter int N = 5
);
    logic               load;
    logic [(1<<N)-1:0]  req;
    logic [N-1:0]       y;
    logic               y_valid;
    logic               y_ready;
    logic               busy;
    logic               done;

    modport master (
        output load,
        output req,
        output y_ready,
        input  y,
        input  y_valid,
        input  busy,
        input  done
    );

    modport slave (
        input  load,
        input  req,
        input  y_ready,
        output y,
        output y_valid,
        output busy,
        output done
    );
endinterface
`default_nettype wire

// File: rtl/n_encoder_seq.sv
`default_nettype none
// ============================================================================
// Module      : n_encoder_seq
// Description : Captures a 2**N-bit request vector and emits the index of
//               every set bit, lowest first, one per valid/ready transfer.
// Revision    : 1.0 - initial release
// ============================================================================
module n_encoder_seq #(
    parameter int N = 5
) (
    input  logic           clk,
    input  logic           rst_n,
    n_encoder_seq_if.slave bus
);
    localparam int W = 1 << N;

    localparam logic [0:0] c_ST_IDLE = 1'b0;
    localparam logic [0:0] c_ST_SCAN = 1'b1;

    logic [0:0]   state_q,   state_d;
    logic [W-1:0] pending_q, pending_d;
    logic [N-1:0] y_q,       y_d;
    logic         y_valid_q, y_valid_d;
    logic         busy_q,    busy_d;
    logic         done_q,    done_d;

    logic [W-1:0] w_remaining;
    logic [W-1:0] w_search;
    logic [N-1:0] w_low_idx;
    logic         w_search_nz;

    // One shared priority encoder: it looks at req while idle and at the
    // pending bits minus the index being handed off while scanning.
    always_comb begin
        w_remaining = pending_q & ~(W'(1) << y_q);
        w_search    = (state_q == c_ST_IDLE) ? bus.req : w_remaining;
        w_search_nz = |w_search;
        w_low_idx   = '0;
        for (int i = W - 1; i >= 0; i--) begin
            if (w_search[i]) begin
                w_low_idx = N'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        y_d       = y_q;
        y_valid_d = y_valid_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        case (state_q)
            c_ST_IDLE: begin
                if (bus.load) begin
                    if (w_search_nz) begin
                        pending_d = bus.req;
                        state_d   = c_ST_SCAN;
                        y_d       = w_low_idx;
                        y_valid_d = 1'b1;
                        busy_d    = 1'b1;
                    end else begin
                        done_d    = 1'b1;
                    end
                end
            end
            c_ST_SCAN: begin
                if (y_valid_q && bus.y_ready) begin
                    pending_d = w_remaining;
                    if (w_search_nz) begin
                        y_d       = w_low_idx;
                    end else begin
                        // y deliberately keeps the last emitted index
                        state_d   = c_ST_IDLE;
                        y_valid_d = 1'b0;
                        busy_d    = 1'b0;
                        done_d    = 1'b1;
                    end
                end
            end
            default: begin
                state_d = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= c_ST_IDLE;
            pending_q <= '0;
            y_q       <= '0;
            y_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.y       = y_q;
    assign bus.y_valid = y_valid_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule
`default_nettype wire

// File: tb/tb_n_encoder_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_n_encoder_seq
// Description : Self-checking bench for n_encoder_seq (N=4) with a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_n_encoder_seq;
    localparam int N = 4;
    localparam int W = 1 << N;

    logic clk;
    logic rst_n;

    n_encoder_seq_if #(.N(N)) bus ();

    n_encoder_seq #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: the list of indices still owed, plus the last y
    int           m_q[$];
    logic [N-1:0] m_y;
    logic         m_done;
    logic [W-1:0] m_captured;
    // Scoreboard
    logic [W-1:0] sb_acc;
    int           sb_last;
    int           log_q[$];

    initial begin
        m_y = '0; m_done = 1'b0; m_captured = '0; sb_acc = '0; sb_last = -1;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_q.delete(); m_y = '0; m_done = 1'b0; sb_acc = '0; sb_last = -1;
            end else begin
                if (bus.y_valid && bus.y_ready) begin
                    check("dup_index", 32'(sb_acc[bus.y]), 32'd0);
                    check("ascending", 32'(int'(bus.y) > sb_last), 32'd1);
                    sb_acc[bus.y] = 1'b1;
                    sb_last = int'(bus.y);
                    log_q.push_back(int'(bus.y));
                end
                m_done = 1'b0;
                if (m_q.size() > 0) begin
                    if (bus.y_ready) begin
                        void'(m_q.pop_front());
                        if (m_q.size() == 0) m_done = 1'b1;
                        else m_y = N'(m_q[0]);
                    end
                end else if (bus.load) begin
                    m_captured = bus.req;
                    sb_acc = '0; sb_last = -1;
                    for (int i = 0; i < W; i++) if (bus.req[i]) m_q.push_back(i);
                    if (m_q.size() == 0) m_done = 1'b1;
                    else m_y = N'(m_q[0]);
                end
            end
            #1;
            check("y_valid", 32'(bus.y_valid), 32'(m_q.size() > 0));
            check("busy",    32'(bus.busy),    32'(m_q.size() > 0));
            check("done",    32'(bus.done),    32'(m_done));
            check("y",       32'(bus.y),       32'(m_y));
            if (m_done) check("rebuild_or", 32'(sb_acc), 32'(m_captured));
        end
    end

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int c = 0; c < 200 && !seen; c++) begin
            @(negedge clk);
            if (bus.done) seen = 1;
        end
        check(name, 32'(seen), 32'd1);
    endtask

    task automatic load_once(input logic [W-1:0] v);
        @(negedge clk);
        bus.load = 1'b1; bus.req = v;
        @(negedge clk);
        bus.load = 1'b0;
    endtask

    task automatic check_log(input string name, input int exp[$]);
        check({name, "_len"}, 32'(log_q.size()), 32'(exp.size()));
        foreach (exp[i]) if (i < log_q.size()) check(name, 32'(log_q[i]), 32'(exp[i]));
    endtask

    initial begin
        int seq[$];
        rst_n = 1'b0; bus.load = 1'b0; bus.req = '0; bus.y_ready = 1'b0;
        #12;
        check("rst_y_valid", 32'(bus.y_valid), 32'd0);
        check("rst_busy",    32'(bus.busy),    32'd0);
        check("rst_done",    32'(bus.done),    32'd0);
        check("rst_y",       32'(bus.y),       32'd0);
        @(negedge clk); rst_n = 1'b1;

        // 1: sparse vector, consumer always ready
        bus.y_ready = 1'b1; log_q.delete();
        load_once(16'h8421);
        wait_done("t1_done");
        check_log("t1_seq", '{0, 5, 10, 15});
        check("t1_busy", 32'(bus.busy), 32'd0);

        // 2: empty vector yields only a done pulse
        @(negedge clk); bus.load = 1'b1; bus.req = 16'h0000;
        @(negedge clk); bus.load = 1'b0;
        check("t2_done",  32'(bus.done),    32'd1);
        check("t2_valid", 32'(bus.y_valid), 32'd0);
        @(negedge clk);
        check("t2_done_gone", 32'(bus.done), 32'd0);

        // 3: all bits set
        log_q.delete();
        load_once(16'hFFFF);
        wait_done("t3_done");
        seq.delete();
        for (int i = 0; i < W; i++) seq.push_back(i);
        check_log("t3_seq", seq);

        // 4: stall with y_ready low
        log_q.delete(); bus.y_ready = 1'b0;
        load_once(16'h0012);
        for (int i = 0; i < 5; i++) begin
            check("t4_stall_y", 32'(bus.y), 32'd1);
            check("t4_stall_v", 32'(bus.y_valid), 32'd1);
            @(negedge clk);
        end
        bus.y_ready = 1'b1;
        wait_done("t4_done");
        check_log("t4_seq", '{1, 4});

        // 5: load while scanning is ignored
        log_q.delete();
        @(negedge clk); bus.load = 1'b1; bus.req = 16'h00F0;
        @(negedge clk); bus.req = 16'h0001;
        @(negedge clk);
        @(negedge clk); bus.load = 1'b0;
        wait_done("t5_done");
        check_log("t5_seq", '{4, 5, 6, 7});

        // 6: asynchronous reset mid-stream
        log_q.delete();
        load_once(16'hA000);
        @(negedge clk); #2; rst_n = 1'b0; #1;
        check("t6_rst_valid", 32'(bus.y_valid), 32'd0);
        check("t6_rst_busy",  32'(bus.busy),    32'd0);
        check("t6_rst_done",  32'(bus.done),    32'd0);
        check("t6_rst_y",     32'(bus.y),       32'd0);
        check_log("t6_pre", '{13});
        @(negedge clk); @(negedge clk); rst_n = 1'b1;
        log_q.delete();
        load_once(16'h0002);
        wait_done("t6_done");
        check_log("t6_seq", '{1});

        // Random traffic against the model
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            bus.load    = ($urandom_range(0, 3) == 0);
            bus.req     = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom & $urandom);
            bus.y_ready = ($urandom_range(0, 3) != 0);
        end
        @(negedge clk); bus.load = 1'b0; bus.y_ready = 1'b1;
        repeat (W + 4) @(negedge clk);
        check("final_idle", 32'(bus.busy), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
